// File: rtl/i2c_tc74_slave.sv
// TC74-style I2C temperature sensor slave with TEMP and CONFIG registers.
// Open-drain SDA: sda_oe=1 pulls the line low.
module i2c_tc74_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1001101
) (
    input  logic       divided_clock,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] temp_in,
    input  logic       temp_valid,
    output logic [7:0] config_out,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK,
        WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
    } state_t;

    state_t     state, state_n;
    logic [2:0] scl_q, sda_q;
    logic [3:0] cnt, cnt_n;
    logic [7:0] rx, rx_n, tx, tx_n;
    logic [7:0] ptr, ptr_n, temp, rd_data;
    logic       rw, rw_n, oe_n, busy_n;
    logic       shdn, shdn_n, data_rdy;
    logic       scl_rise, scl_fall, start, stop;

    // [1] is the synchronized value, [2] its previous sample
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start    = ~sda_q[1] & sda_q[2] & scl_q[1] & scl_q[2];
    assign stop     = sda_q[1] & ~sda_q[2] & scl_q[1] & scl_q[2];

    assign config_out = {shdn, data_rdy, 6'd0};

    always_comb begin
        case (ptr)
            8'h00:   rd_data = temp;
            8'h01:   rd_data = config_out;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge divided_clock) begin
        if (!reset) begin
            scl_q    <= 3'b111;
            sda_q    <= 3'b111;
            temp     <= 8'h00;
            data_rdy <= 1'b0;
        end else begin
            scl_q <= {scl_q[1:0], scl_in};
            sda_q <= {sda_q[1:0], sda_in};
            if (temp_valid && !shdn) begin
                temp     <= temp_in;
                data_rdy <= 1'b1;
            end
        end
    end

    always_ff @(posedge divided_clock) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            rx     <= 8'h00;
            tx     <= 8'h00;
            ptr    <= 8'h00;
            rw     <= 1'b0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
            shdn   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rx     <= rx_n;
            tx     <= tx_n;
            ptr    <= ptr_n;
            rw     <= rw_n;
            sda_oe <= oe_n;
            busy   <= busy_n;
            shdn   <= shdn_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rx_n    = rx;
        tx_n    = tx;
        ptr_n   = ptr;
        rw_n    = rw;
        oe_n    = sda_oe;
        busy_n  = busy;
        shdn_n  = shdn;
        if (start) begin
            state_n = ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ADDR, CMD, WDATA: begin
                    if (scl_rise) begin
                        rx_n  = {rx[6:0], sda_q[1]};
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n = 4'd0;
                            if (state == ADDR) begin
                                if (rx_n[7:1] == SLAVE_ADDR) begin
                                    busy_n  = 1'b1;
                                    rw_n    = rx_n[0];
                                    state_n = ADDR_ACK;
                                end else begin
                                    busy_n  = 1'b0;
                                    state_n = WAIT_STOP;
                                end
                            end else if (state == CMD) begin
                                ptr_n   = rx_n;
                                state_n = CMD_ACK;
                            end else begin
                                if (ptr == 8'h01)
                                    shdn_n = rx_n[7];
                                state_n = WDATA_ACK;
                            end
                        end
                    end
                end
                // cnt=0: waiting for the fall that starts the ACK slot
                ADDR_ACK, CMD_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (cnt == 4'd0) begin
                            oe_n  = 1'b1;
                            cnt_n = 4'd1;
                        end else begin
                            oe_n    = 1'b0;
                            cnt_n   = 4'd0;
                            state_n = WDATA;
                            if (state == ADDR_ACK) begin
                                if (rw) begin
                                    tx_n    = rd_data;
                                    oe_n    = ~rd_data[7];
                                    cnt_n   = 4'd1;
                                    state_n = RDATA;
                                end else begin
                                    state_n = CMD;
                                end
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            oe_n    = 1'b0;
                            state_n = RACK;
                        end else begin
                            oe_n  = ~tx[~cnt[2:0]];
                            cnt_n = cnt + 4'd1;
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (sda_q[1]) begin
                            state_n = WAIT_STOP;
                        end else begin
                            tx_n    = rd_data;
                            cnt_n   = 4'd0;
                            state_n = RDATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_tc74_slave.sv
// Directed bench: bus-level master driving the TC74 slave.
module tb_i2c_tc74_slave;
    localparam int Q = 40;
    localparam int H = 80;

    logic       divided_clock;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] temp_in;
    logic       temp_valid;
    logic [7:0] config_out;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic       ack;
    logic [7:0] d1, d2;
    logic       oe_seen;
    logic       dummy;

    assign sda_line = sda_m & ~sda_oe;

    i2c_tc74_slave dut (
        .divided_clock(divided_clock),
        .reset        (reset),
        .scl_in       (scl),
        .sda_in       (sda_line),
        .sda_oe       (sda_oe),
        .temp_in      (temp_in),
        .temp_valid   (temp_valid),
        .config_out   (config_out),
        .busy         (busy)
    );

    initial divided_clock = 1'b0;
    always #5 divided_clock = ~divided_clock;

    always @(posedge divided_clock)
        if (sda_oe === 1'b1)
            oe_seen = 1'b1;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        #Q scl = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        #Q scl = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic bit_clk(input logic b, output logic s);
        sda_m = b;
        #Q scl = 1'b1;
        #(H / 2) s = sda_line;
        #(H / 2) scl = 1'b0;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        logic s;
        for (int i = 7; i >= 0; i--)
            bit_clk(b[i], s);
        bit_clk(1'b1, a);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_clk(1'b1, s);
            d = {d[6:0], s};
        end
        bit_clk(mack, s);
        sda_m = 1'b1;
    endtask

    task automatic pulse_temp(input logic [7:0] t);
        temp_in    = t;
        temp_valid = 1'b1;
        #10 temp_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        scl        = 1'b1;
        sda_m      = 1'b1;
        temp_in    = 8'h00;
        temp_valid = 1'b0;
        oe_seen    = 1'b0;
        #100;
        chk("rst_oe", {7'd0, sda_oe}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_cfg", config_out, 8'h00);
        reset = 1'b1;
        #100;

        // Basic read of TEMP
        pulse_temp(8'h19);
        chk("rdy_cfg", config_out, 8'h40);
        i2c_start();
        write_byte(8'h9B, ack);
        chk("r1_ack", {7'd0, ack}, 8'h00);
        chk("r1_busy", {7'd0, busy}, 8'h01);
        read_byte(d1, 1'b1);
        chk("r1_data", d1, 8'h19);
        chk("r1_busy_hold", {7'd0, busy}, 8'h01);
        i2c_stop();
        #100;
        chk("r1_busy_end", {7'd0, busy}, 8'h00);

        // Pointer to CONFIG, repeated START, read
        i2c_start();
        write_byte(8'h9A, ack);
        chk("w2_ack_a", {7'd0, ack}, 8'h00);
        write_byte(8'h01, ack);
        chk("w2_ack_c", {7'd0, ack}, 8'h00);
        i2c_start();
        write_byte(8'h9B, ack);
        chk("r2_ack", {7'd0, ack}, 8'h00);
        read_byte(d1, 1'b1);
        chk("r2_cfg", d1, 8'h40);
        i2c_stop();
        #100;

        // Shutdown holds TEMP
        i2c_start();
        write_byte(8'h9A, ack);
        write_byte(8'h01, ack);
        write_byte(8'h80, ack);
        chk("w3_ack_d", {7'd0, ack}, 8'h00);
        i2c_stop();
        #100;
        chk("w3_cfg", config_out, 8'hC0);
        pulse_temp(8'hE7);
        #50;
        i2c_start();
        write_byte(8'h9B, ack);
        read_byte(d1, 1'b1);
        chk("r3_cfg", d1, 8'hC0);
        i2c_stop();
        #100;
        i2c_start();
        write_byte(8'h9A, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'h9B, ack);
        read_byte(d1, 1'b1);
        chk("r3_temp", d1, 8'h19);
        i2c_stop();
        #100;

        // Leave shutdown; PTR back to TEMP
        i2c_start();
        write_byte(8'h9A, ack);
        write_byte(8'h01, ack);
        write_byte(8'h00, ack);
        i2c_stop();
        #100;
        chk("w4_cfg", config_out, 8'h40);
        i2c_start();
        write_byte(8'h9A, ack);
        write_byte(8'h00, ack);
        i2c_stop();
        #100;

        // Wrong address
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'h90, ack);
        chk("na_ack", {7'd0, ack}, 8'h01);
        chk("na_busy", {7'd0, busy}, 8'h00);
        write_byte(8'h55, ack);
        chk("na_oe", {7'd0, oe_seen}, 8'h00);
        i2c_stop();
        #100;

        // Two-byte read with mid-byte temperature update
        i2c_start();
        write_byte(8'h9B, ack);
        chk("r5_ack", {7'd0, ack}, 8'h00);
        fork
            read_byte(d1, 1'b0);
            begin
                #400;
                pulse_temp(8'h05);
            end
        join
        read_byte(d2, 1'b1);
        chk("r5_b1", d1, 8'h19);
        chk("r5_b2", d2, 8'h05);
        i2c_stop();
        #100;

        // Reset while driving a data bit
        i2c_start();
        write_byte(8'h9B, ack);
        bit_clk(1'b1, dummy);
        bit_clk(1'b1, dummy);
        bit_clk(1'b1, dummy);
        chk("r6_drive", {7'd0, sda_oe}, 8'h01);
        reset = 1'b0;
        @(posedge divided_clock);
        #1;
        chk("r6_rel", {7'd0, sda_oe}, 8'h00);
        chk("r6_busy", {7'd0, busy}, 8'h00);
        @(negedge divided_clock);
        #20;
        reset = 1'b1;
        #40;
        chk("r6_cfg", config_out, 8'h00);
        oe_seen = 1'b0;
        bit_clk(1'b1, dummy);
        bit_clk(1'b0, dummy);
        chk("r6_quiet", {7'd0, oe_seen}, 8'h00);
        i2c_stop();
        #100;
        i2c_start();
        write_byte(8'h9B, ack);
        chk("r7_ack", {7'd0, ack}, 8'h00);
        read_byte(d1, 1'b1);
        chk("r7_temp", d1, 8'h00);
        i2c_stop();
        #100;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_tc74_slave.md
I2C_TC74_SLAVE -- requirements
Module: i2c_tc74_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b1001101, the 7-bit I2C address this device answers to.
REQ-002 SHALL have port divided_clock, input, 1, the sole clock; all logic samples on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-004 SHALL have port scl_in, input, 1, I2C SCL from the bus, asynchronous to divided_clock.
REQ-005 SHALL have port sda_in, input, 1, I2C SDA read back from the bus, asynchronous.
REQ-006 SHALL have port sda_oe, output, 1; 1 means pull SDA low, 0 means release SDA (open-drain).
REQ-007 SHALL have port temp_in, input, 8, two's-complement temperature to report.
REQ-008 SHALL have port temp_valid, input, 1, single-cycle strobe that captures temp_in.
REQ-009 SHALL have port config_out, output, 8, the current configuration register (CONFIG).
REQ-010 SHALL have port busy, output, 1, high from an address-matched START until the following STOP or address mismatch.

Function
REQ-011 SHALL pass scl_in and sda_in through 2-flop synchronizers and detect edges on the synchronized values, giving 3 cycles of input latency; divided_clock SHALL be at least 8x the SCL frequency.
REQ-012 SHALL detect START as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-013 SHALL treat a START in any state, including a repeated START mid-byte, as abort-and-restart: go to ADDR, clear the bit counter, and release sda_oe.
REQ-014 SHALL respond to a STOP in any state by going to IDLE, releasing sda_oe, and clearing busy.
REQ-015 SHALL implement these states: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
REQ-016 SHALL sample SDA on SCL rising edges, MSB first, and SHALL change sda_oe only in the cycle after a detected SCL falling edge.
REQ-017 ADDR: after 8 bits, on a match of bits[7:1] with SLAVE_ADDR SHALL set busy and go to ADDR_ACK; on a mismatch SHALL go to WAIT_STOP with no ACK.
REQ-018 ACK states (ADDR_ACK, CMD_ACK, WDATA_ACK) SHALL drive sda_oe=1 from the falling edge after the 8th bit until the next falling edge.
REQ-019 After ADDR_ACK, R/W=0 SHALL lead to CMD and R/W=1 SHALL lead to RDATA, with the shift register loaded from the register selected by PTR.
REQ-020 CMD: the received byte SHALL be stored in PTR and the byte SHALL always be ACKed; afterwards SHALL go to WDATA.
REQ-021 WDATA: if PTR=8'h01, SHALL write bit7 of the received byte to CONFIG[7] (SHDN); any other PTR SHALL discard the byte; the byte SHALL always be ACKed, and further bytes SHALL repeat WDATA.
REQ-022 Read mapping SHALL be: PTR=8'h00 returns TEMP; PTR=8'h01 returns CONFIG; any other PTR returns 8'h00.
REQ-023 RDATA: on each SCL falling edge SHALL drive sda_oe = ~current bit, for 8 bits, then release.
REQ-024 RACK: SHALL sample the master bit on the SCL rising edge; ACK (0) SHALL reload the same register and return to RDATA; NACK (1) SHALL go to WAIT_STOP.
REQ-025 SHALL capture temp_in into TEMP on temp_valid; the read shift register SHALL hold its load-time snapshot, so a mid-byte temp_valid does not alter the byte in flight.
REQ-026 CONFIG[6] (DATA_RDY) SHALL be set by the first temp_valid and SHALL be read-only; CONFIG[5:0] SHALL read 0.
REQ-027 While CONFIG[7]=1, temp_valid SHALL be ignored and TEMP SHALL be held.
REQ-028 PTR SHALL persist across transactions; only a CMD byte changes it.

Reset
REQ-029 When reset=0 at a clock edge, the block SHALL set state=IDLE, sda_oe=0, busy=0, PTR=8'h00, TEMP=8'h00, CONFIG=8'h00, config_out=8'h00, and clear the synchronizers to 1.
REQ-030 A reset asserted mid-transaction SHALL release SDA within 1 cycle, and the block SHALL ignore the bus until the next START.

Verification
REQ-031 temp_valid with temp_in=8'h19, then START, 0x9B, read, NACK, STOP -> byte 0x19 read, address ACKed, busy 1->0 at STOP.
REQ-032 START, 0x9A, 0x01, repeated START, 0x9B, read -> byte 8'h40 (DATA_RDY set, SHDN clear).
REQ-033 Write 0x9A, 0x01, 0x80, STOP, then temp_valid with 8'hE7, then read PTR=1 and PTR=0 -> 8'hC0 and 8'h19 (TEMP held).
REQ-034 START, 0x90 (wrong address) -> no ACK on the 9th clock, sda_oe=0 throughout, busy=0.
REQ-035 Read with master ACK, then 2nd byte, NACK -> both bytes equal TEMP; temp_valid mid-byte with 8'h05 -> 1st byte unchanged, 2nd byte 8'h05.
REQ-036 reset=0 during the RDATA bit 3 drive -> sda_oe=0 next cycle; a later full read returns TEMP=8'h00.
